// File: rtl/keypad_code_entry.sv
// Keypad code entry: assembles keypad key events into a multi-digit BCD code
// with backspace, submit over valid/ready, and inactivity timeout of partial entries.
`timescale 1ns/1ps
module keypad_code_entry #(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CW             = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_value,
  output logic [4*MAX_DIGITS-1:0] code_bcd,
  output logic [CW-1:0]           digit_count,
  output logic                    code_valid,
  input  logic                    code_ready,
  output logic                    key_error,
  output logic                    timeout
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] FULL      = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ENTRY,
    S_HOLD
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_code;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_err;
  logic          r_to;
  logic [TW-1:0] r_idle;

  logic          w_is_digit;
  logic          w_is_back;
  logic          w_is_submit;
  logic [3:0]    w_digit;
  logic          w_full;
  logic          w_expired;
  logic [DW-1:0] w_pushed;
  logic [DW-1:0] w_popped;

  always_comb begin
    w_is_digit  = ((key_value >= 4'd1) && (key_value <= 4'd9)) || (key_value == 4'd11);
    w_is_back   = (key_value == 4'd10);
    w_is_submit = (key_value == 4'd12);
    w_digit     = (key_value == 4'd11) ? 4'd0 : key_value;
    w_full      = (r_count == FULL);
    w_expired   = (TIMEOUT_CYCLES > 0) && (r_idle == IDLE_LAST);
    w_pushed    = (r_code << 4) | DW'(w_digit);
    w_popped    = r_code >> 4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_code  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
      r_idle  <= '0;
    end else begin
      r_err <= 1'b0;
      r_to  <= 1'b0;
      unique case (r_state)
        S_EMPTY: begin
          r_idle <= '0;
          if (key_valid) begin
            if (w_is_digit) begin
              r_code  <= w_pushed;
              r_count <= r_count + CW'(1);
              r_state <= S_ENTRY;
            end else if (!w_is_back) begin
              // '#' with nothing entered and invalid codes are both rejected
              r_err <= 1'b1;
            end
          end
        end

        S_ENTRY: begin
          if (key_valid) begin
            // a key on the expiry cycle takes priority over the timeout
            r_idle <= '0;
            if (w_is_digit) begin
              if (w_full) begin
                r_err <= 1'b1;
              end else begin
                r_code  <= w_pushed;
                r_count <= r_count + CW'(1);
              end
            end else if (w_is_back) begin
              r_code  <= w_popped;
              r_count <= r_count - CW'(1);
              if (r_count == CW'(1)) r_state <= S_EMPTY;
            end else if (w_is_submit) begin
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_expired) begin
            r_to    <= 1'b1;
            r_code  <= '0;
            r_count <= '0;
            r_idle  <= '0;
            r_state <= S_EMPTY;
          end else if (TIMEOUT_CYCLES > 0) begin
            r_idle <= r_idle + TW'(1);
          end
        end

        S_HOLD: begin
          r_idle <= '0;
          if (key_valid) r_err <= 1'b1;
          if (r_valid && code_ready) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_count <= '0;
            r_state <= S_EMPTY;
          end
        end

        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign code_bcd    = r_code;
  assign digit_count = r_count;
  assign code_valid  = r_valid;
  assign key_error   = r_err;
  assign timeout     = r_to;

endmodule
